// File: rtl/vsf_pkg.sv
// Shared constants and state encoding for the vertex stream feeder.
package vsf_pkg;

  localparam int MAT_WORDS = 16;
  localparam int VTX_WORDS = 4;
  localparam int OUT_WORDS = 32;
  localparam logic [31:0] FLOAT_ONE = 32'h3F80_0000;

  typedef enum logic [1:0] {
    IDLE,
    MLOAD,
    EMIT
  } state_e;

endpackage

// File: rtl/vsf_mat_regs.sv
// 4x4 transform register file, row-major, one write port and one read port.
// Resets to the identity so vertices sent before any matrix load pass through.
module vsf_mat_regs
  import vsf_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [3:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [3:0]        raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [MAT_WORDS];

  // NOTE: this array is flops, not RAM, so it can carry a reset value; the
  // identity must be restored on every reset, not just at power-up.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAT_WORDS; i++) begin
        mem_q[i] <= ((i / 4) == (i % 4)) ? DATA_W'(FLOAT_ONE) : '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vertex_stream_feeder.sv
// Demultiplexes one FSL stream into matrix loads and vertices, then replays
// each vertex as the 32-word M[r][c]/V[c] interleave that matrixmult consumes.
module vertex_stream_feeder
  import vsf_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              FSL_Clk,
  input  logic              FSL_Rst,
  input  logic [DATA_W-1:0] FSL_S_Data,
  input  logic              FSL_S_Control,
  input  logic              FSL_S_Exists,
  output logic              FSL_S_Read,
  output logic [DATA_W-1:0] FSL_M_Data,
  output logic              FSL_M_Write,
  output logic              FSL_M_Control,
  input  logic              FSL_M_Full
);

  localparam logic [4:0] LAST_OUT = 5'(OUT_WORDS - 1);

  state_e            state_q, state_d;
  logic [3:0]        mload_idx_q, mload_idx_d;
  logic [1:0]        vidx_q, vidx_d;
  logic [4:0]        oidx_q, oidx_d;
  logic [DATA_W-1:0] vtx_q [VTX_WORDS];

  logic              mat_we;
  logic [3:0]        mat_waddr;
  logic [DATA_W-1:0] mat_rdata;
  logic              vtx_we;

  vsf_mat_regs #(.DATA_W(DATA_W)) u_mat_regs (
    .clk_i   (FSL_Clk),
    .rst_ni  (FSL_Rst),
    .we_i    (mat_we),
    .waddr_i (mat_waddr),
    .wdata_i (FSL_S_Data),
    .raddr_i ({oidx_q[4:3], oidx_q[2:1]}),
    .rdata_o (mat_rdata)
  );

  assign FSL_S_Read    = FSL_S_Exists && (state_q != EMIT);
  assign FSL_M_Write   = (state_q == EMIT) && !FSL_M_Full;
  assign FSL_M_Control = FSL_M_Write && (oidx_q == LAST_OUT);
  // Odd output slots carry V[c], even slots carry M[r][c].
  assign FSL_M_Data    = oidx_q[0] ? vtx_q[oidx_q[2:1]] : mat_rdata;

  // NOTE: every signal gets its default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    mload_idx_d = mload_idx_q;
    vidx_d      = vidx_q;
    oidx_d      = oidx_q;
    mat_we      = 1'b0;
    mat_waddr   = mload_idx_q;
    vtx_we      = 1'b0;

    unique case (state_q)
      IDLE, MLOAD: begin
        if (FSL_S_Read) begin
          if (FSL_S_Control) begin
            // A control word always (re)starts a load and drops any partial vertex.
            mat_we      = 1'b1;
            mat_waddr   = 4'd0;
            mload_idx_d = 4'd1;
            vidx_d      = 2'd0;
            state_d     = MLOAD;
          end else if (state_q == MLOAD) begin
            mat_we = 1'b1;
            if (mload_idx_q == 4'(MAT_WORDS - 1)) begin
              state_d = IDLE;
            end else begin
              mload_idx_d = mload_idx_q + 4'd1;
            end
          end else begin
            vtx_we = 1'b1;
            if (vidx_q == 2'(VTX_WORDS - 1)) begin
              state_d = EMIT;
              oidx_d  = 5'd0;
            end else begin
              vidx_d = vidx_q + 2'd1;
            end
          end
        end
      end
      EMIT: begin
        if (FSL_M_Write) begin
          oidx_d = oidx_q + 5'd1;
          if (oidx_q == LAST_OUT) begin
            state_d = IDLE;
            vidx_d  = 2'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge FSL_Clk) begin
    if (!FSL_Rst) begin
      state_q     <= IDLE;
      mload_idx_q <= '0;
      vidx_q      <= '0;
      oidx_q      <= '0;
      for (int i = 0; i < VTX_WORDS; i++) vtx_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      mload_idx_q <= mload_idx_d;
      vidx_q      <= vidx_d;
      oidx_q      <= oidx_d;
      if (vtx_we) vtx_q[vidx_q] <= FSL_S_Data;
    end
  end

endmodule

// File: tb/tb_vertex_stream_feeder.sv
// Directed bench: identity pass-through, matrix load, backpressure, partial
// vertex discard and mid-stream reset.
module tb_vertex_stream_feeder;

  logic        clk = 1'b0;
  logic        fsl_rst;
  logic [31:0] s_data;
  logic        s_ctrl;
  logic        s_exists;
  logic        s_read;
  logic [31:0] m_data;
  logic        m_write;
  logic        m_ctrl;
  logic        m_full;

  int checks   = 0;
  int failures = 0;

  logic [31:0] cur_mat [16];
  logic [31:0] cur_vtx [4];
  logic [31:0] exp_seq [32];
  logic [31:0] got     [32];

  always #5 clk = ~clk;

  vertex_stream_feeder #(.DATA_W(32)) dut (
    .FSL_Clk       (clk),
    .FSL_Rst       (fsl_rst),
    .FSL_S_Data    (s_data),
    .FSL_S_Control (s_ctrl),
    .FSL_S_Exists  (s_exists),
    .FSL_S_Read    (s_read),
    .FSL_M_Data    (m_data),
    .FSL_M_Write   (m_write),
    .FSL_M_Control (m_ctrl),
    .FSL_M_Full    (m_full)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_word(input logic [31:0] d, input logic c);
    s_data   = d;
    s_ctrl   = c;
    s_exists = 1'b1;
    @(negedge clk);
    check("s_read", {31'b0, s_read}, 32'd1);
    check("no_write_in", {31'b0, m_write}, 32'd0);
    @(posedge clk);
    #1;
    s_exists = 1'b0;
    s_ctrl   = 1'b0;
  endtask

  task automatic send_vertex();
    for (int i = 0; i < 4; i++) send_word(cur_vtx[i], 1'b0);
  endtask

  task automatic load_matrix();
    for (int i = 0; i < 16; i++) send_word(cur_mat[i], i == 0);
  endtask

  task automatic build_exp();
    for (int k = 0; k < 16; k++) begin
      exp_seq[2*k]   = cur_mat[k];
      exp_seq[2*k+1] = cur_vtx[k % 4];
    end
  endtask

  // Collects `limit` written words; Data must show the pending word even while Full.
  task automatic run_emit(input bit rand_full, input bit hold_exists, input int limit);
    int n   = 0;
    int cyc = 0;
    if (hold_exists) begin
      s_exists = 1'b1;
      s_data   = 32'hDEAD_BEEF;
    end
    while (n < limit && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("latency_write", {31'b0, m_write}, 32'd1);
      check("m_data", m_data, exp_seq[n]);
      if (hold_exists) check("s_read_emit", {31'b0, s_read}, 32'd0);
      if (m_write) begin
        check("m_ctrl", {31'b0, m_ctrl}, {31'b0, n == 31});
        got[n] = m_data;
        n++;
      end
      @(posedge clk);
      #1;
      if (n == limit) s_exists = 1'b0;
      m_full = (rand_full && n < limit) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    check("emit_count", 32'(n), 32'(limit));
    if (limit == 32) begin
      @(negedge clk);
      check("idle_after_write", {31'b0, m_write}, 32'd0);
      check("idle_after_ctrl", {31'b0, m_ctrl}, 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    fsl_rst  = 1'b0;
    s_data   = '0;
    s_ctrl   = 1'b0;
    s_exists = 1'b0;
    m_full   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_read", {31'b0, s_read}, 32'd0);
    check("rst_m_write", {31'b0, m_write}, 32'd0);
    check("rst_m_data", m_data, 32'h3F80_0000);
    check("rst_m_ctrl", {31'b0, m_ctrl}, 32'd0);
    @(posedge clk);
    #1;
    fsl_rst = 1'b1;

    // Vertex against the reset identity matrix.
    for (int i = 0; i < 16; i++) cur_mat[i] = ((i / 4) == (i % 4)) ? 32'h3F80_0000 : 32'h0;
    cur_vtx = '{32'hBF07_AE14, 32'h4141_999A, 32'hC169_1EB8, 32'h4040_A3D7};
    build_exp();
    send_vertex();
    run_emit(1'b0, 1'b0, 32);
    check("id_w0", got[0], 32'h3F80_0000);
    check("id_w1", got[1], 32'hBF07_AE14);
    check("id_w2", got[2], 32'h0000_0000);
    check("id_w10", got[10], 32'h3F80_0000);
    check("id_w31", got[31], 32'h4040_A3D7);

    // Load a real transform, then the same vertex.
    cur_mat = '{32'h4124_CCCD, 32'h40C8_0000, 32'h40A9_999A, 32'h3C4C_CCCD,
                32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000,
                32'h4110_0000, 32'h4120_0000, 32'h4130_0000, 32'h4124_CCCD};
    load_matrix();
    build_exp();
    send_vertex();
    run_emit(1'b0, 1'b0, 32);
    check("mat_w0", got[0], 32'h4124_CCCD);
    check("mat_w1", got[1], 32'hBF07_AE14);
    check("mat_w2", got[2], 32'h40C8_0000);
    check("mat_w3", got[3], 32'h4141_999A);
    check("mat_w30", got[30], 32'h4124_CCCD);
    check("mat_w31", got[31], 32'h4040_A3D7);

    // Backpressure: Full toggles randomly, Exists held high throughout EMIT.
    send_vertex();
    run_emit(1'b1, 1'b1, 32);

    // Partial vertex discarded by a new matrix load.
    send_word(32'h1111_1111, 1'b0);
    send_word(32'h2222_2222, 1'b0);
    for (int i = 0; i < 16; i++) cur_mat[i] = 32'h4100_0000 | 32'(i);
    load_matrix();
    cur_vtx = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};
    build_exp();
    send_vertex();
    run_emit(1'b0, 1'b0, 32);
    check("part_w0", got[0], 32'h4100_0000);
    check("part_w1", got[1], 32'hA000_0001);
    check("part_w31", got[31], 32'hA000_0004);

    // Reset while word 10 is on the output.
    send_vertex();
    run_emit(1'b0, 1'b0, 10);
    fsl_rst = 1'b0;
    @(posedge clk);
    #1;
    fsl_rst = 1'b1;
    @(negedge clk);
    check("midrst_write", {31'b0, m_write}, 32'd0);
    check("midrst_data", m_data, 32'h3F80_0000);
    check("midrst_ctrl", {31'b0, m_ctrl}, 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) cur_mat[i] = ((i / 4) == (i % 4)) ? 32'h3F80_0000 : 32'h0;
    cur_vtx = '{32'hBF07_AE14, 32'h4141_999A, 32'hC169_1EB8, 32'h4040_A3D7};
    build_exp();
    send_vertex();
    run_emit(1'b0, 1'b0, 32);
    check("post_rst_w0", got[0], 32'h3F80_0000);
    check("post_rst_w2", got[2], 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
